// File: rtl/comparador_jogadas_if.sv
// Play request and result bundle between the player front-end and the comparator.
interface comparador_jogadas_if #(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int CW = 8
);
  logic [N*W-1:0] indices;
  logic [N-1:0]   jogada;
  logic           jogada_valida;
  logic           ocupado;
  logic           pronto;
  logic           acerto;
  logic           erro;
  logic [N-1:0]   mascara;
  logic [CW-1:0]  num_acertos;
  logic [CW-1:0]  num_erros;

  modport master (
    output indices, jogada, jogada_valida,
    input  ocupado, pronto, acerto, erro, mascara, num_acertos, num_erros
  );

  modport slave (
    input  indices, jogada, jogada_valida,
    output ocupado, pronto, acerto, erro, mascara, num_acertos, num_erros
  );
endinterface

// File: rtl/comparador_jogadas.sv
// Latches a play, matches each pressed lane against ALVO, keeps saturating hit/miss counts; pronto two edges after the accepting edge.
// No backpressure: one result per press, ESPERA holds until jogada_valida drops. COMPARADOR_JOGADAS_ESTRITO_EN: multi-press plays are misses.
module comparador_jogadas #(
  parameter int             N    = 4,
  parameter int             W    = 2,
  parameter logic [W-1:0]   ALVO = '0,
  parameter int             CW   = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                zera,
  comparador_jogadas_if.slave bus
);

  typedef enum logic [1:0] {OCIOSO, AVALIA, RESPOSTA, ESPERA} estado_t;

  localparam logic [CW-1:0] SATURADO = '1;

  estado_t        estado, prox;
  logic           captura, avalia_en, pronto_set;
  logic [N*W-1:0] idx_q;
  logic [N-1:0]   jog_q;
  logic [N-1:0]   masc_calc;
  logic           acerto_calc;
  logic           pronto_q, acerto_q, erro_q;
  logic [N-1:0]   mascara_q;
  logic [CW-1:0]  acertos_q, erros_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= OCIOSO;
    else          estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:   if (bus.jogada_valida && (|bus.jogada)) prox = AVALIA;
      AVALIA:   prox = RESPOSTA;
      RESPOSTA: prox = ESPERA;
      ESPERA:   if (!bus.jogada_valida) prox = OCIOSO;
      default:  prox = OCIOSO;
    endcase
    if (zera) prox = OCIOSO;
  end

  // zera suppresses every datapath update on its edge
  always_comb begin
    captura    = (estado == OCIOSO) && (prox == AVALIA);
    avalia_en  = (estado == AVALIA) && !zera;
    pronto_set = (estado == RESPOSTA) && !zera;
  end

  always_comb begin
    masc_calc = '0;
    for (int k = 0; k < N; k++)
      masc_calc[k] = (idx_q[k*W +: W] == ALVO) && jog_q[k];
`ifdef COMPARADOR_JOGADAS_ESTRITO_EN
    if ((jog_q & (jog_q - N'(1))) != '0) masc_calc = '0;
`endif
    acerto_calc = |masc_calc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      jog_q <= '0;
    end else if (captura) begin
      idx_q <= bus.indices;
      jog_q <= bus.jogada;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pronto_q  <= 1'b0;
      acerto_q  <= 1'b0;
      erro_q    <= 1'b0;
      mascara_q <= '0;
      acertos_q <= '0;
      erros_q   <= '0;
    end else if (zera) begin
      pronto_q  <= 1'b0;
      acerto_q  <= 1'b0;
      erro_q    <= 1'b0;
      mascara_q <= '0;
      acertos_q <= '0;
      erros_q   <= '0;
    end else begin
      pronto_q <= pronto_set;
      if (avalia_en) begin
        acerto_q  <= acerto_calc;
        erro_q    <= !acerto_calc;
        mascara_q <= masc_calc;
        if (acerto_calc && (acertos_q != SATURADO)) acertos_q <= acertos_q + CW'(1);
        if (!acerto_calc && (erros_q != SATURADO))  erros_q   <= erros_q + CW'(1);
      end
    end
  end

  assign bus.ocupado     = (estado != OCIOSO);
  assign bus.pronto      = pronto_q;
  assign bus.acerto      = acerto_q;
  assign bus.erro        = erro_q;
  assign bus.mascara     = mascara_q;
  assign bus.num_acertos = acertos_q;
  assign bus.num_erros   = erros_q;

endmodule

// File: tb/tb_comparador_jogadas.sv
// Directed bench for comparador_jogadas with N=4, W=2, ALVO=0, CW=2 (small CW exposes saturation).
module tb_comparador_jogadas;
  localparam int N  = 4;
  localparam int W  = 2;
  localparam int CW = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic zera    = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   ac      = 0;
  int   er      = 0;
  int   pulses  = 0;

  always #5 clock = ~clock;

  comparador_jogadas_if #(.N(N), .W(W), .CW(CW)) bus ();

  comparador_jogadas #(.N(N), .W(W), .ALVO(2'b00), .CW(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .zera    (zera),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one play for a single edge, scrambles inputs afterwards, stops in the pronto cycle.
  task automatic play(input logic [7:0] idx, input logic [3:0] jog);
    bus.indices       = idx;
    bus.jogada        = jog;
    bus.jogada_valida = 1'b1;
    tick();
    chk("ocupado_latch", 32'(bus.ocupado), 1);
    bus.jogada_valida = 1'b0;
    bus.indices       = ~idx;
    bus.jogada        = ~jog;
    tick();
    chk("pronto_early", 32'(bus.pronto), 0);
    tick();
    chk("pronto", 32'(bus.pronto), 1);
  endtask

  task automatic result(input string tag, input logic a, input int m);
    if (a) begin
      if (ac < 3) ac++;
    end else if (er < 3) er++;
    chk({tag, "_acerto"},  32'(bus.acerto), a ? 1 : 0);
    chk({tag, "_erro"},    32'(bus.erro), a ? 0 : 1);
    chk({tag, "_mascara"}, 32'(bus.mascara), m);
    chk({tag, "_nacertos"}, 32'(bus.num_acertos), ac);
    chk({tag, "_nerros"},  32'(bus.num_erros), er);
    tick();
    chk({tag, "_pronto_off"}, 32'(bus.pronto), 0);
    chk({tag, "_idle"},    32'(bus.ocupado), 0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ocupado"},  32'(bus.ocupado), 0);
    chk({tag, "_pronto"},   32'(bus.pronto), 0);
    chk({tag, "_acerto"},   32'(bus.acerto), 0);
    chk({tag, "_erro"},     32'(bus.erro), 0);
    chk({tag, "_mascara"},  32'(bus.mascara), 0);
    chk({tag, "_nacertos"}, 32'(bus.num_acertos), 0);
    chk({tag, "_nerros"},   32'(bus.num_erros), 0);
  endtask

  initial begin
    bus.indices       = '0;
    bus.jogada        = '0;
    bus.jogada_valida = 1'b0;
    tick();
    tick();
    all_zero("reset");
    reset_n = 1'b1;
    tick();

    // lane 3 carries the target and is pressed
    play(8'b00_01_10_11, 4'b1000);
    result("hit", 1'b1, 8);

    // lane 2 pressed, only lane 0 is a target
    play(8'b01_01_01_00, 4'b0100);
    result("miss", 1'b0, 0);

    bus.jogada_valida = 1'b1;
    bus.jogada        = 4'b0000;
    tick();
    tick();
    chk("empty_ignored", 32'(bus.ocupado), 0);
    bus.jogada_valida = 1'b0;

    bus.indices       = 8'b11_11_11_00;
    bus.jogada        = 4'b0001;
    bus.jogada_valida = 1'b1;
    pulses            = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.pronto) pulses++;
    end
    chk("hold_pulses", 32'(pulses), 1);
    chk("hold_ocupado", 32'(bus.ocupado), 1);
    bus.jogada_valida = 1'b0;
    ac++;
    tick();
    chk("hold_release", 32'(bus.ocupado), 0);
    chk("hold_nacertos", 32'(bus.num_acertos), ac);

    play(8'b00_00_11_11, 4'b1001);
`ifdef COMPARADOR_JOGADAS_ESTRITO_EN
    result("multi", 1'b0, 0);
`else
    result("multi", 1'b1, 8);
`endif

    zera = 1'b1;
    tick();
    zera = 1'b0;
    ac   = 0;
    er   = 0;
    all_zero("zera");

    for (int i = 0; i < 5; i++) begin
      play(8'b11_11_11_00, 4'b0001);
      result("sat", 1'b1, 1);
    end
    play(8'b11_11_11_00, 4'b0010);
    result("sat_miss", 1'b0, 0);

    // reset asserted while the FSM is in AVALIA
    bus.indices       = 8'b11_11_11_00;
    bus.jogada        = 4'b0001;
    bus.jogada_valida = 1'b1;
    tick();
    chk("avalia_ocupado", 32'(bus.ocupado), 1);
    #2 reset_n = 1'b0;
    #1;
    ac = 0;
    er = 0;
    all_zero("async_reset");
    tick();
    tick();
    chk("reset_no_pronto", 32'(bus.pronto), 0);
    reset_n = 1'b1;
    tick();
    chk("post_reset_accept", 32'(bus.ocupado), 1);
    bus.jogada_valida = 1'b0;
    tick();
    chk("post_reset_pronto_early", 32'(bus.pronto), 0);
    tick();
    chk("post_reset_pronto", 32'(bus.pronto), 1);
    result("post_reset", 1'b1, 1);

    // zera wins over a simultaneous request
    bus.jogada        = 4'b0001;
    bus.jogada_valida = 1'b1;
    zera              = 1'b1;
    tick();
    zera              = 1'b0;
    bus.jogada_valida = 1'b0;
    ac = 0;
    er = 0;
    all_zero("zera_req");
    tick();
    tick();
    chk("zera_req_no_pronto", 32'(bus.pronto), 0);
    chk("zera_req_idle", 32'(bus.ocupado), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/comparador_jogadas.md
COMPARADOR_JOGADAS -- requirements
Module: comparador_jogadas

Interface
REQ-001 Parameter N, 4, number of positions (lanes), N >= 1.
REQ-002 Parameter W, 2, index width per position, W >= 1.
REQ-003 Parameter ALVO, 0, index value marking a position as target; W bits wide.
REQ-004 Parameter CW, 8, width of hit and miss counters.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 zera  in  1  synchronous clear of counters, outputs and FSM.
REQ-008 indices  in  N*W  lane k index = indices[k*W +: W].
REQ-009 jogada  in  N  player buttons; bit k pairs with lane k.
REQ-010 jogada_valida  in  1  level request; a play is presented while high.
REQ-011 ocupado  out  1  high whenever FSM is not OCIOSO.
REQ-012 pronto  out  1  one-cycle pulse: result outputs valid.
REQ-013 acerto  out  1  registered result: play was a hit.
REQ-014 erro  out  1  registered result: play was a miss.
REQ-015 mascara  out  N  registered per-lane hit mask of last play.
REQ-016 num_acertos  out  CW  hit count; num_erros out CW miss count.

Function
REQ-017 FSM states: OCIOSO, AVALIA, RESPOSTA, ESPERA; encoding free.
REQ-018 OCIOSO: jogada_valida=1 and jogada!=0 -> latch indices and jogada, go to AVALIA; jogada_valida=1 with jogada==0 is ignored (stay).
REQ-019 AVALIA: mascara[k] = (latched index k == ALVO) and latched jogada[k]; acerto = OR of mascara; erro = not acerto; increment matching counter; go to RESPOSTA.
REQ-020 RESPOSTA: pronto=1 for exactly this cycle; go to ESPERA.
REQ-021 ESPERA: stay while jogada_valida=1; go to OCIOSO on first cycle jogada_valida=0 (one result per press).
REQ-022 Latency: request sampled at edge t -> pronto high in the cycle after edge t+2.
REQ-023 Input changes on indices/jogada after the latch edge do not affect the current result.
REQ-024 acerto, erro, mascara hold their value until the next AVALIA, zera or reset.
REQ-025 Exactly one of acerto/erro is high after the first evaluated play; both 0 before it.
REQ-026 Counters saturate at 2^CW-1; no wrap-around; the saturated counter's update is dropped, the other is unaffected.
REQ-027 zera=1: next edge clears counters, acerto, erro, mascara, pronto; FSM -> OCIOSO; zera has priority over any simultaneous request or evaluation.

Reset
REQ-028 reset_n=0 asynchronously forces FSM=OCIOSO and all outputs and counters to 0, including mid-evaluation.
REQ-029 After reset_n rises, a held jogada_valida=1 with jogada!=0 is accepted as a new play on the next edge.

Configuration
REQ-030 Macro COMPARADOR_JOGADAS_ESTRITO_EN defined: a latched jogada with more than one bit set is a miss (acerto=0, erro=1, mascara=0) regardless of indices.
REQ-031 Macro undefined: any-hit semantics per REQ-019; multiple pressed bits allowed.

Verification
REQ-032 N=4,W=2: indices=8'b00_01_10_11, jogada=4'b1000, valida pulse -> 2 edges later pronto=1, acerto=1, mascara=4'b1000, num_acertos=1.
REQ-033 indices=8'b01_01_01_00, jogada=4'b0100 -> acerto=0, erro=1, mascara=0, num_erros=1.
REQ-034 jogada_valida held 10 cycles with jogada=4'b0001 on target lane -> exactly one pronto pulse, num_acertos increments by 1.
REQ-035 CW=2, 5 hits -> num_acertos=3 after hits 3,4,5; num_erros=0.
REQ-036 indices=8'b00_00_11_11, jogada=4'b1001: without macro acerto=1, mascara=4'b1000; with macro acerto=0, erro=1.
REQ-037 reset_n=0 in AVALIA cycle -> immediately ocupado=0, counters=0, no pronto; zera with simultaneous request -> request dropped, all outputs 0.
